input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 123 ++++++++++++
 tb/tb_input_conditioner.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Input conditioner for arcade controls: synchronises, debounces and edge-detects
// button/joystick channels, applies autofire, and stretches reset requests.
module input_conditioner #(
  parameter int                  CHANNELS        = 8,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW      = '0,
  parameter int                  DEBOUNCE_CYCLES = 16,
  parameter int                  AF_HALF         = 4,
  parameter int                  RST_SRCS        = 3,
  parameter int                  RST_STRETCH     = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_in,
  input  logic [CHANNELS-1:0] af_en,
  input  logic [RST_SRCS-1:0] rst_src,
  output logic [CHANNELS-1:0] btn_state,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] af_out,
  output logic                rst_out
);

  localparam int DebW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AfW  = (AF_HALF > 1) ? $clog2(AF_HALF) : 1;
  localparam int RstW = $clog2(RST_STRETCH + 1);

  localparam logic [DebW-1:0] DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AfW-1:0]  AfLast   = AfW'(AF_HALF - 1);
  localparam logic [RstW-1:0] RstLoad  = RstW'(RST_STRETCH);

  logic [CHANNELS-1:0]            rawSync1_q, rawSync2_q;
  logic [CHANNELS-1:0][DebW-1:0]  debCnt_q, debCnt_d;
  logic [CHANNELS-1:0]            btnState_q, btnState_d;
  logic [CHANNELS-1:0]            btnPress_q, btnPress_d;
  logic [CHANNELS-1:0]            btnRelease_q, btnRelease_d;
  logic [CHANNELS-1:0]            afOut_q, afOut_d;
  logic [AfW-1:0]                 afCnt_q, afCnt_d;
  logic                           afPhase_q, afPhase_d;
  logic [RST_SRCS-1:0]            rstSync1_q, rstSync2_q;
  logic [RstW-1:0]                rstCnt_q, rstCnt_d;
  logic                           rstOut_q, rstOut_d;

  // A channel flips only after DEBOUNCE_CYCLES consecutive mismatching cycles.
  always_comb begin
    btnState_d   = btnState_q;
    btnPress_d   = '0;
    btnRelease_d = '0;
    debCnt_d     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rawSync2_q[i] != btnState_q[i]) begin
        if (debCnt_q[i] == DebLast) begin
          btnState_d[i]   = ~btnState_q[i];
          btnPress_d[i]   = ~btnState_q[i];
          btnRelease_d[i] = btnState_q[i];
        end else begin
          debCnt_d[i] = debCnt_q[i] + DebW'(1);
        end
      end
    end
  end

  always_comb begin
    afCnt_d   = afCnt_q + AfW'(1);
    afPhase_d = afPhase_q;
    if (afCnt_q == AfLast) begin
      afCnt_d   = '0;
      afPhase_d = ~afPhase_q;
    end
    afOut_d = btnState_q & (~af_en | {CHANNELS{afPhase_q}});
  end

  // Any live request reloads the stretch; rst_out drops on the cycle the count hits zero.
  always_comb begin
    rstCnt_d = rstCnt_q;
    rstOut_d = 1'b0;
    if (|rstSync2_q) begin
      rstCnt_d = RstLoad;
      rstOut_d = 1'b1;
    end else if (rstCnt_q != '0) begin
      rstCnt_d = rstCnt_q - RstW'(1);
      rstOut_d = (rstCnt_q != RstW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rawSync1_q   <= '0;
      rawSync2_q   <= '0;
      debCnt_q     <= '0;
      btnState_q   <= '0;
      btnPress_q   <= '0;
      btnRelease_q <= '0;
      afOut_q      <= '0;
      afCnt_q      <= '0;
      afPhase_q    <= 1'b1;
      rstSync1_q   <= '0;
      rstSync2_q   <= '0;
      rstCnt_q     <= RstLoad;
      rstOut_q     <= 1'b1;
    end else begin
      rawSync1_q   <= raw_in ^ ACTIVE_LOW;
      rawSync2_q   <= rawSync1_q;
      debCnt_q     <= debCnt_d;
      btnState_q   <= btnState_d;
      btnPress_q   <= btnPress_d;
      btnRelease_q <= btnRelease_d;
      afOut_q      <= afOut_d;
      afCnt_q      <= afCnt_d;
      afPhase_q    <= afPhase_d;
      rstSync1_q   <= rst_src;
      rstSync2_q   <= rstSync1_q;
      rstCnt_q     <= rstCnt_d;
      rstOut_q     <= rstOut_d;
    end
  end

  assign btn_state   = btnState_q;
  assign btn_press   = btnPress_q;
  assign btn_release = btnRelease_q;
  assign af_out      = afOut_q;
  assign rst_out     = rstOut_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: a cycle model pushes expected outputs as
// stimulus is applied; a negedge monitor pops and compares them.
module tb_input_conditioner;

  localparam int         CH   = 4;
  localparam int         DEB  = 8;
  localparam int         AFH  = 4;
  localparam int         NSRC = 2;
  localparam int         RSTR = 16;
  localparam logic [3:0] AL   = 4'b0010;
  localparam logic [3:0] IDLE = 4'b0010;

  logic            clk = 1'b0;
  logic            reset;
  logic [CH-1:0]   raw_in, af_en;
  logic [NSRC-1:0] rst_src;
  logic [CH-1:0]   btn_state, btn_press, btn_release, af_out;
  logic            rst_out;

  input_conditioner #(
    .CHANNELS(CH), .ACTIVE_LOW(AL), .DEBOUNCE_CYCLES(DEB),
    .AF_HALF(AFH), .RST_SRCS(NSRC), .RST_STRETCH(RSTR)
  ) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in), .af_en(af_en), .rst_src(rst_src),
    .btn_state(btn_state), .btn_press(btn_press), .btn_release(btn_release),
    .af_out(af_out), .rst_out(rst_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] state;
    logic [CH-1:0] press;
    logic [CH-1:0] rel;
    logic [CH-1:0] af;
    logic          rstOut;
  } expT;

  expT sbQ[$];
  int  checks = 0;
  int  errors = 0;
  int  edgeCount = 0;
  int  pressEdge[CH];

  logic [CH-1:0]   mSync1, mSync2, mState;
  int              mCnt[CH];
  int              mSinceRst;
  int              mAge;
  logic [NSRC-1:0] mSrc1, mSrc2;

  always @(posedge clk) edgeCount++;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Autofire phase derived from edges since reset: starts high, flips every AFH edges.
  function automatic logic phaseOf(input int n);
    return ((n / AFH) % 2) == 0;
  endfunction

  task automatic applyStimulus(input logic [CH-1:0] raw, input logic [CH-1:0] afe,
                               input logic [NSRC-1:0] src, input logic rst);
    expT           e;
    logic [CH-1:0] nState;
    raw_in  = raw;
    af_en   = afe;
    rst_src = src;
    reset   = rst;
    if (rst) begin
      mSync1 = '0; mSync2 = '0; mState = '0;
      for (int i = 0; i < CH; i++) mCnt[i] = 0;
      mSinceRst = 0; mAge = 0; mSrc1 = '0; mSrc2 = '0;
      e.state = '0; e.press = '0; e.rel = '0; e.af = '0; e.rstOut = 1'b1;
    end else begin
      e.af    = mState & (~afe | {CH{phaseOf(mSinceRst)}});
      e.press = '0;
      e.rel   = '0;
      nState  = mState;
      for (int i = 0; i < CH; i++) begin
        if (mSync2[i] != mState[i]) begin
          if (mCnt[i] == DEB - 1) begin
            nState[i] = ~mState[i];
            mCnt[i]   = 0;
            if (nState[i]) e.press[i] = 1'b1;
            else           e.rel[i]   = 1'b1;
          end else begin
            mCnt[i]++;
          end
        end else begin
          mCnt[i] = 0;
        end
      end
      mState  = nState;
      e.state = nState;
      mSync2  = mSync1;
      mSync1  = raw ^ AL;
      if (mSrc2 != '0) mAge = 0;
      else if (mAge < 1000) mAge++;
      mSrc2 = mSrc1;
      mSrc1 = src;
      e.rstOut = (mAge < RSTR);
      mSinceRst++;
    end
    sbQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [CH-1:0] raw, input logic [CH-1:0] afe,
                      input logic [NSRC-1:0] src, input int n);
    for (int k = 0; k < n; k++) applyStimulus(raw, afe, src, 1'b0);
  endtask

  task automatic clearPressEdges();
    for (int i = 0; i < CH; i++) pressEdge[i] = -1;
  endtask

  always @(negedge clk) begin
    expT e;
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput("btnState", 32'(btn_state), 32'(e.state));
      checkOutput("btnPress", 32'(btn_press), 32'(e.press));
      checkOutput("btnRelease", 32'(btn_release), 32'(e.rel));
      checkOutput("afOut", 32'(af_out), 32'(e.af));
      checkOutput("rstOut", 32'(rst_out), 32'(e.rstOut));
      checkOutput("pressRelExcl", 32'(btn_press & btn_release), 32'd0);
      for (int i = 0; i < CH; i++) if (btn_press[i]) pressEdge[i] = edgeCount;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int            start;
    logic [CH-1:0] rawV, afeV;
    clearPressEdges();
    for (int k = 0; k < 3; k++) applyStimulus(IDLE, '0, '0, 1'b1);
    hold(IDLE, '0, '0, 20);

    $display("[TB] single press/release on channel 0");
    clearPressEdges();
    start = edgeCount;
    hold(4'b0011, '0, '0, 15);
    checkOutput("press0Latency", 32'(pressEdge[0] - start), 32'd10);
    hold(IDLE, '0, '0, 15);

    $display("[TB] short glitch on channel 2");
    clearPressEdges();
    hold(4'b0110, '0, '0, 7);
    hold(IDLE, '0, '0, 12);
    checkOutput("glitch2NoPress", 32'(pressEdge[2]), 32'hFFFF_FFFF);

    $display("[TB] active-low channel 1");
    clearPressEdges();
    start = edgeCount;
    hold(4'b0000, '0, '0, 15);
    checkOutput("press1Latency", 32'(pressEdge[1] - start), 32'd10);
    hold(IDLE, '0, '0, 15);

    $display("[TB] autofire on channel 3");
    hold(4'b1010, 4'b1000, '0, 40);
    hold(4'b1010, '0, '0, 10);
    hold(IDLE, '0, '0, 15);

    $display("[TB] reset request stretching");
    hold(IDLE, '0, 2'b10, 1);
    hold(IDLE, '0, '0, 8);
    hold(IDLE, '0, 2'b10, 1);
    hold(IDLE, '0, '0, 25);

    $display("[TB] all channels pressed together");
    clearPressEdges();
    start = edgeCount;
    hold(4'b1101, '0, '0, 15);
    for (int i = 0; i < CH; i++) checkOutput($sformatf("pressAll%0d", i), 32'(pressEdge[i] - start), 32'd10);
    hold(IDLE, '0, '0, 15);

    $display("[TB] reset during debounce");
    hold(4'b0011, '0, '0, 4);
    applyStimulus(4'b0011, '0, '0, 1'b1);
    clearPressEdges();
    start = edgeCount;
    hold(4'b0011, '0, '0, 15);
    checkOutput("pressAfterReset", 32'(pressEdge[0] - start), 32'd10);
    hold(IDLE, '0, '0, 12);

    $display("[TB] random segments");
    for (int s = 0; s < 25; s++) begin
      rawV = 4'($urandom);
      afeV = 4'($urandom);
      if ($urandom_range(0, 5) == 0) hold(rawV, afeV, 2'($urandom), 1);
      hold(rawV, afeV, '0, $urandom_range(1, 12));
    end

    @(negedge clk);
    #1;
    checkOutput("sbDrain", 32'(sbQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
